// File: rtl/program_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte image into instruction RAM and holds the CPU in reset until loaded.
// Release 1 cycle after the last byte; ByteReady is a pure state decode (low in RUN/ERR), one byte per cycle otherwise.
module program_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    input  logic [31:0] InstAddr,
    output logic [31:0] Instruction,
    input  logic        Halt,
    output logic        CpuRst,
    output logic        Loaded,
    output logic        Error
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    localparam logic [2:0] ST_HDR_LO = 3'd0;
    localparam logic [2:0] ST_HDR_HI = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [1:0]            lane_q, lane_d;
    logic [23:0]           asm_q, asm_d;
    logic                  cpu_rst_q, loaded_q, error_q;

    logic [31:0]           mem [DEPTH];
    logic                  mem_we;
    logic [31:0]           mem_wdat;

    logic                  accept;
    logic [15:0]           n_full;
    logic                  n_bad;
    logic                  last_word;

    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_hi_zero;
    logic                  rd_ok;

    assign ByteReady = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) ||
                       (state_q == ST_DATA)   || (state_q == ST_HALTED);
    assign accept    = ByteValid && ByteReady;

    // Header range check is done in 32-bit arithmetic so N = 2^ADDR_WIDTH fits.
    assign n_full    = {ByteIn, n_q[7:0]};
    assign n_bad     = (n_full == 16'd0) || (32'(n_full) > DEPTH);
    assign last_word = (32'(wptr_q) == (32'(n_q) - 32'd1));
    assign mem_wdat  = {ByteIn, asm_q};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        wptr_d  = wptr_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_HDR_LO: begin
                if (accept) begin
                    n_d     = {8'h00, ByteIn};
                    state_d = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (accept) begin
                    n_d = n_full;
                    if (n_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        wptr_d  = '0;
                        lane_d  = 2'd0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (lane_q == 2'd3) begin
                        mem_we = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        lane_d = 2'd0;
                        if (last_word) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        lane_d = lane_q + 2'd1;
                        case (lane_q)
                            2'd0:    asm_d[7:0]   = ByteIn;
                            2'd1:    asm_d[15:8]  = ByteIn;
                            default: asm_d[23:16] = ByteIn;
                        endcase
                    end
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                // A byte here is the low header byte of a reload; Halt is ignored.
                if (accept) begin
                    n_d     = {8'h00, ByteIn};
                    state_d = ST_HDR_HI;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_HDR_LO;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_HDR_LO;
            n_q       <= 16'd0;
            wptr_q    <= '0;
            lane_q    <= 2'd0;
            asm_q     <= 24'd0;
            cpu_rst_q <= 1'b1;
            loaded_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            wptr_q    <= wptr_d;
            lane_q    <= lane_d;
            asm_q     <= asm_d;
            cpu_rst_q <= !((state_d == ST_RUN) || (state_d == ST_HALTED));
            loaded_q  <= (state_d == ST_RUN) || (state_d == ST_HALTED);
            error_q   <= (state_d == ST_ERR);
        end
    end

    // RAM is never cleared; the index < N gate below hides stale contents.
    always_ff @(posedge Clk) begin
        if (mem_we && !Rst) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= mem_wdat;
        end
    end

    assign rd_idx      = InstAddr[ADDR_WIDTH+1:2];
    assign rd_hi_zero  = ((InstAddr >> (ADDR_WIDTH + 2)) == 32'd0);
    assign rd_ok       = loaded_q && rd_hi_zero && (32'(rd_idx) < 32'(n_q));
    assign Instruction = rd_ok ? mem[rd_idx] : 32'h0000_0000;

    assign CpuRst = cpu_rst_q;
    assign Loaded = loaded_q;
    assign Error  = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random images and gaps against a word-level image model.
module tb_program_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [7:0]  ByteIn = 8'h00;
    logic        ByteValid = 1'b0;
    logic        ByteReady;
    logic [31:0] InstAddr = 32'h0;
    logic [31:0] Instruction;
    logic        Halt = 1'b0;
    logic        CpuRst;
    logic        Loaded;
    logic        Error;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .Clk(Clk), .Rst(Rst), .ByteIn(ByteIn), .ByteValid(ByteValid),
        .ByteReady(ByteReady), .InstAddr(InstAddr), .Instruction(Instruction),
        .Halt(Halt), .CpuRst(CpuRst), .Loaded(Loaded), .Error(Error)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_mem [DEPTH];
    int          exp_n = 0;
    bit          exp_loaded = 1'b0;
    logic [31:0] img_q [$];
    bit          pre_cpu_rst;

    // Model: a loaded image of N words is visible at word addresses 0..N-1 only.
    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        int idx;
        if (!exp_loaded) return 32'h0;
        if ((a >> (AW + 2)) != 0) return 32'h0;
        idx = int'(a >> 2);
        if (idx >= exp_n) return 32'h0;
        return exp_mem[idx];
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1; ByteValid = 1'b0; Halt = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        exp_loaded = 1'b0;
        exp_n = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waitc;
        repeat (gap) begin
            ByteValid = 1'b0;
            @(negedge Clk);
        end
        ByteValid = 1'b1;
        ByteIn = b;
        waitc = 0;
        while (!ByteReady && waitc < 50) begin
            @(negedge Clk);
            waitc++;
        end
        n_checks++;
        if (ByteReady !== 1'b1) begin
            n_errors++;
            $display("FAIL send_byte_timeout: ByteReady=%b required 1", ByteReady);
        end
        pre_cpu_rst = CpuRst;
        @(negedge Clk);
        ByteValid = 1'b0;
    endtask

    task automatic halt_pulse();
        @(negedge Clk);
        Halt = 1'b1;
        @(negedge Clk);
        Halt = 1'b0;
    endtask

    task automatic load_image(input int gapmax);
        int n;
        n = img_q.size();
        @(negedge Clk);
        send_byte(n[7:0], $urandom_range(0, gapmax));
        exp_loaded = 1'b0;
        n_checks++;
        if (CpuRst !== 1'b1 || Loaded !== 1'b0) begin
            n_errors++;
            $display("FAIL load_first_byte: CpuRst=%b Loaded=%b required 1 0", CpuRst, Loaded);
        end
        Halt = 1'b0;
        send_byte(n[15:8], $urandom_range(0, gapmax));
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(img_q[w][8*b +: 8], $urandom_range(0, gapmax));
            end
        end
        exp_n = n;
        for (int i = 0; i < n; i++) exp_mem[i] = img_q[i];
        exp_loaded = 1'b1;
        n_checks++;
        if (pre_cpu_rst !== 1'b1 || CpuRst !== 1'b0 || Loaded !== 1'b1 ||
            ByteReady !== 1'b0 || Error !== 1'b0) begin
            n_errors++;
            $display("FAIL load_release: preCpuRst=%b CpuRst=%b Loaded=%b ByteReady=%b Error=%b required 1 0 1 0 0",
                     pre_cpu_rst, CpuRst, Loaded, ByteReady, Error);
        end
    endtask

    task automatic test_reset();
        do_reset();
        InstAddr = 32'h0;
        #1;
        n_checks++;
        if (CpuRst !== 1'b1 || Loaded !== 1'b0 || Error !== 1'b0 ||
            ByteReady !== 1'b1 || Instruction !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: CpuRst=%b Loaded=%b Error=%b ByteReady=%b Instr=%h required 1 0 0 1 0",
                     CpuRst, Loaded, Error, ByteReady, Instruction);
        end
    endtask

    task automatic test_basic_load();
        logic [31:0] addrs [7];
        addrs = '{32'h0, 32'h4, 32'h8, 32'h1, 32'h3, 32'h100, 32'h8000_0000};
        do_reset();
        img_q = '{32'h2008000C, 32'h0000_0000};
        load_image(0);
        for (int i = 0; i < 7; i++) begin
            @(negedge Clk);
            InstAddr = addrs[i];
            #1;
            n_checks++;
            if (Instruction !== exp_instr(addrs[i])) begin
                n_errors++;
                $display("FAIL basic_fetch addr=%h: got %h required %h", addrs[i], Instruction, exp_instr(addrs[i]));
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        img_q = '{32'h2008000C, 32'h0000_0000};
        load_image(3);
        for (int a = 0; a < 12; a += 4) begin
            @(negedge Clk);
            InstAddr = a;
            #1;
            n_checks++;
            if (Instruction !== exp_instr(a)) begin
                n_errors++;
                $display("FAIL gaps_fetch addr=%0d: got %h required %h", a, Instruction, exp_instr(a));
            end
        end
    endtask

    task automatic test_halt_reload();
        halt_pulse();
        Halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            InstAddr = 32'h0;
            #1;
            n_checks++;
            if (Loaded !== 1'b1 || CpuRst !== 1'b0 || ByteReady !== 1'b1 ||
                Instruction !== exp_instr(32'h0)) begin
                n_errors++;
                $display("FAIL halted_state: Loaded=%b CpuRst=%b ByteReady=%b Instr=%h required 1 0 1 %h",
                         Loaded, CpuRst, ByteReady, Instruction, exp_instr(32'h0));
            end
        end
        img_q = '{$urandom};
        load_image(1);
        for (int a = 0; a < 8; a += 4) begin
            @(negedge Clk);
            InstAddr = a;
            #1;
            n_checks++;
            if (Instruction !== exp_instr(a)) begin
                n_errors++;
                $display("FAIL reload_fetch addr=%0d: got %h required %h", a, Instruction, exp_instr(a));
            end
        end
    endtask

    task automatic test_run_hold_valid();
        @(negedge Clk);
        ByteValid = 1'b1;
        ByteIn = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            n_checks++;
            if (ByteReady !== 1'b0 || CpuRst !== 1'b0 || Loaded !== 1'b1) begin
                n_errors++;
                $display("FAIL run_hold_valid: ByteReady=%b CpuRst=%b Loaded=%b required 0 0 1",
                         ByteReady, CpuRst, Loaded);
            end
        end
        ByteValid = 1'b0;
        halt_pulse();
        img_q = '{$urandom};
        load_image(0);
        @(negedge Clk);
        InstAddr = 32'h0;
        #1;
        n_checks++;
        if (Instruction !== exp_instr(32'h0)) begin
            n_errors++;
            $display("FAIL run_hold_reload: got %h required %h", Instruction, exp_instr(32'h0));
        end
    endtask

    task automatic test_random_loads();
        logic [31:0] a;
        for (int it = 0; it < 5; it++) begin
            halt_pulse();
            img_q.delete();
            for (int w = 0; w < int'($urandom_range(1, 12)); w++) img_q.push_back($urandom);
            load_image(2);
            for (int w = 0; w < img_q.size() + 2; w++) begin
                @(negedge Clk);
                a = (w * 4) | $urandom_range(0, 3);
                InstAddr = a;
                #1;
                n_checks++;
                if (Instruction !== exp_instr(a)) begin
                    n_errors++;
                    $display("FAIL random_fetch it=%0d addr=%h: got %h required %h", it, a, Instruction, exp_instr(a));
                end
            end
            @(negedge Clk);
            a = 32'h0 | (32'h1 << $urandom_range(AW + 2, 31));
            InstAddr = a;
            #1;
            n_checks++;
            if (Instruction !== exp_instr(a)) begin
                n_errors++;
                $display("FAIL random_highbits addr=%h: got %h required %h", a, Instruction, exp_instr(a));
            end
        end
    endtask

    task automatic test_full_depth();
        logic [31:0] addrs [4];
        addrs = '{32'h0, (DEPTH - 1) * 4, DEPTH * 4, (DEPTH / 2) * 4 + 2};
        halt_pulse();
        img_q.delete();
        for (int w = 0; w < DEPTH; w++) img_q.push_back($urandom);
        load_image(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            InstAddr = addrs[i];
            #1;
            n_checks++;
            if (Instruction !== exp_instr(addrs[i])) begin
                n_errors++;
                $display("FAIL full_depth addr=%h: got %h required %h", addrs[i], Instruction, exp_instr(addrs[i]));
            end
        end
    endtask

    task automatic test_error();
        int bad_n [2];
        bad_n = '{0, DEPTH + 1};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            send_byte(bad_n[k][7:0], 0);
            send_byte(bad_n[k][15:8], 0);
            ByteValid = 1'b1;
            ByteIn = 8'h55;
            InstAddr = 32'h0;
            for (int i = 0; i < 4; i++) begin
                #1;
                n_checks++;
                if (Error !== 1'b1 || ByteReady !== 1'b0 || CpuRst !== 1'b1 ||
                    Loaded !== 1'b0 || Instruction !== 32'h0) begin
                    n_errors++;
                    $display("FAIL error_state n=%0d: Error=%b ByteReady=%b CpuRst=%b Loaded=%b Instr=%h required 1 0 1 0 0",
                             bad_n[k], Error, ByteReady, CpuRst, Loaded, Instruction);
                end
                @(negedge Clk);
            end
            ByteValid = 1'b0;
            do_reset();
            n_checks++;
            if (Error !== 1'b0 || ByteReady !== 1'b1) begin
                n_errors++;
                $display("FAIL error_clear: Error=%b ByteReady=%b required 0 1", Error, ByteReady);
            end
        end
    endtask

    task automatic test_midload_reset();
        logic [31:0] w0;
        do_reset();
        w0 = $urandom;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(w0[7:0], 0);
        send_byte(w0[15:8], 0);
        send_byte(w0[23:16], 0);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        exp_loaded = 1'b0;
        InstAddr = 32'h0;
        #1;
        n_checks++;
        if (CpuRst !== 1'b1 || Loaded !== 1'b0 || Error !== 1'b0 ||
            ByteReady !== 1'b1 || Instruction !== 32'h0) begin
            n_errors++;
            $display("FAIL midload_reset: CpuRst=%b Loaded=%b Error=%b ByteReady=%b Instr=%h required 1 0 0 1 0",
                     CpuRst, Loaded, Error, ByteReady, Instruction);
        end
        img_q = '{$urandom, $urandom};
        load_image(1);
        for (int a = 0; a < 12; a += 4) begin
            @(negedge Clk);
            InstAddr = a;
            #1;
            n_checks++;
            if (Instruction !== exp_instr(a)) begin
                n_errors++;
                $display("FAIL midload_reload addr=%0d: got %h required %h", a, Instruction, exp_instr(a));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_load();
        test_gaps();
        test_halt_reload();
        test_run_hold_valid();
        test_random_loads();
        test_full_depth();
        test_error();
        test_midload_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction-memory loader sitting directly upstream of the MIPS pipeline's IF stage. It accepts a program image as a byte stream over a valid/ready handshake, assembles little-endian 32-bit words into an internal instruction RAM, and holds the processor in reset until the image is complete. It then serves `Instruction` for the processor's `InstAddr` and supports reloading a new image after the processor signals `Halt`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: log2 of RAM depth in 32-bit words (default 1024 words).

Ports:
- `Clk`  in  1  clock; all state changes on its rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `ByteIn`  in  8  image byte.
- `ByteValid`  in  1  `ByteIn` is valid.
- `ByteReady`  out  1  loader accepts a byte this cycle. A byte transfers on a rising edge where `ByteValid && ByteReady`.
- `InstAddr`  in  32  byte address from the processor PC.
- `Instruction`  out  32  instruction word to the processor, combinational.
- `Halt`  in  1  processor halt request.
- `CpuRst`  out  1  registered reset to the processor.
- `Loaded`  out  1  image present and processor released.
- `Error`  out  1  bad header; sticky until `Rst`.

## Operation
Image format: 2-byte little-endian word count N, then 4·N bytes. Each word is little-endian: the first byte of a word goes to `[7:0]`, the last to `[31:24]`.

States are `HDR_LO`, `HDR_HI`, `DATA`, `RUN`, `HALTED`, `ERR`.
- `HDR_LO`: `ByteReady`=1. An accepted byte goes to N[7:0]; next state is `HDR_HI`.
- `HDR_HI`: `ByteReady`=1. An accepted byte goes to N[15:8].
  - If the complete N is 0 or N > 2^ADDR_WIDTH, go to `ERR`.
  - Otherwise clear the word pointer `wptr` and the byte lane counter, and go to `DATA`.
- `DATA`: `ByteReady`=1. Each accepted byte fills the lane selected by the 2-bit lane counter.
  - On the 4th byte, the full word (assembled byte lanes plus the current byte) is written to `mem[wptr]` in that same edge. `wptr` then increments and the lane counter wraps to 0.
  - When the write is to `wptr` = N−1, go to `RUN`.
- `RUN`: `ByteReady`=0. If `Halt`=1 at a rising edge, go to `HALTED`.
- `HALTED`: `ByteReady`=1. An accepted byte is a new header low byte: store it in N[7:0] and go to `HDR_HI`. `CpuRst` reasserts on that same edge.
- `ERR`: `ByteReady`=0. Leaves only on `Rst`.

Output rules:
- `CpuRst` = 1 in every state except `RUN` and `HALTED`.
- `Loaded` = 1 only in `RUN` and `HALTED`.
- `Error` = 1 only in `ERR`.
- `Instruction` = mem[`InstAddr[ADDR_WIDTH+1:2]`] when in `RUN` or `HALTED` and the word index < N. Otherwise it is 32'h0, a MIPS NOP.
- `InstAddr[1:0]` is ignored. `InstAddr` bits above `ADDR_WIDTH+1` that are nonzero force 32'h0.
- RAM contents are not cleared by `Rst`. The index < N gating guarantees no stale or X words reach the processor.

Width rules:
- N is 16 bits, compared against 2^ADDR_WIDTH with at least 17-bit arithmetic.
- `wptr` is `ADDR_WIDTH`+1 bits wide.

## Timing
- `Rst`: state `HDR_LO`, N=0, `wptr`=0, lane=0. Outputs: `CpuRst`=1, `Loaded`=0, `Error`=0, `ByteReady`=1, `Instruction`=0.
- `Rst` mid-load or mid-run aborts immediately to `HDR_LO`. A partially assembled word is discarded.
- `CpuRst`, `Loaded` and `Error` are registered from the state. `ByteReady` is a decode of the registered state, so it has no combinational path from `ByteValid`.
- Release latency: the edge that accepts the final image byte writes the RAM and enters `RUN`. `CpuRst` falls in the cycle after that edge, and the processor fetches from `InstAddr`=0 with the word already valid.
- Throughput: one byte per cycle. `ByteValid` gaps of any length only stall progress; nothing is lost.
- A `ByteValid` byte presented in `RUN` or `ERR` is not consumed, because `ByteReady`=0.
- `Halt` is sampled only in `RUN`. `Halt` held high in `HALTED` has no effect.
- In `HALTED`, if a byte is accepted on the same edge that `Halt` is high, the byte wins: the loader starts the reload.

## Test plan
- Load N=2 with bytes 02 00 | 0C 00 08 20 | 00 00 00 00 at one byte per cycle.
  - Expect `CpuRst` to fall 1 cycle after the 10th byte and `Loaded`=1.
  - `InstAddr`=0 gives 32'h2008000C; 4 gives 0; 8 gives 0, since index ≥ N.
- Same image with random 0–3 cycle `ByteValid` gaps → identical RAM contents and release timing relative to the last byte.
- Header 00 00 → `Error`=1, `ByteReady`=0, `CpuRst`=1.
  - Header N = 2^ADDR_WIDTH+1 gives the same result.
  - Only `Rst` clears the error.
- Run, assert `Halt` for 1 cycle → `HALTED`, with `Instruction` still served.
  - Then send a new 1-word image → `CpuRst`=1 from the first accepted byte.
  - After release, address 0 returns the new word and address 4 returns 0.
- Assert `Rst` after 5 of 10 image bytes → `HDR_LO`, with all outputs at reset values.
  - A full reload afterwards succeeds.
- Hold `ByteValid`=1 in `RUN` → no byte consumed and `ByteReady` stays 0.
